// File: rtl/gpu_bus_pkg.sv
// Shared definitions for the CPU-facing GPU bus blocks: register map, memory
// region layout and the prefetch FSM encoding.
package gpu_bus_pkg;

  localparam logic [2:0] REG_PTR_LO = 3'd4;
  localparam logic [2:0] REG_PTR_HI = 3'd5;
  localparam logic [2:0] REG_DATA   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam logic [15:0] TILE_BASE  = 16'h0000;
  localparam logic [15:0] TILE_LIMIT = 16'h07FF;
  localparam logic [15:0] ATTR_BASE  = 16'h0800;
  localparam logic [15:0] ATTR_LIMIT = 16'h17FF;
  localparam int          COLOR_SPAN = 16;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_ISSUE   = 2'd1,
    PF_CAPTURE = 2'd2
  } pf_state_e;

  typedef enum logic [1:0] {
    RGN_NONE  = 2'd0,
    RGN_TILE  = 2'd1,
    RGN_ATTR  = 2'd2,
    RGN_COLOR = 2'd3
  } region_e;

  typedef struct packed {
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
  } cpu_req_t;

  // Color window compared at 17 bits so a base near 16'hFFFF cannot wrap.
  function automatic region_e decode_region(input logic [15:0] ptr,
                                            input logic [15:0] color_base);
    region_e rg;
    rg = RGN_NONE;
    if (ptr <= TILE_LIMIT)
      rg = RGN_TILE;
    else if (ptr >= ATTR_BASE && ptr <= ATTR_LIMIT)
      rg = RGN_ATTR;
    else if ({1'b0, ptr} >= {1'b0, color_base} &&
             {1'b0, ptr} <  {1'b0, color_base} + 17'(COLOR_SPAN))
      rg = RGN_COLOR;
    return rg;
  endfunction

endpackage

// File: rtl/cpu_clk_sync.sv
// Brings the CPU bus clock into the GPU clock domain and flags its rising edge
// as a one-cycle pulse.
module cpu_clk_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_clk_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES:0]   chain;
  logic              last_q;

  assign chain = {sync_q, cpu_clk_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= chain[STAGES-1:0];
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/bus_read_interface.sv
// CPU read side of the GPU bus: auto-incrementing VRAM pointer with a one-byte
// prefetch buffer fed from the tile, attribute or color memory.
module bus_read_interface
  import gpu_bus_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] COLOR_BASE  = 16'h1800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_clk,
  input  logic        cs,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        tile_memory_read_enable,
  output logic [10:0] tile_memory_read_addr,
  input  logic [7:0]  tile_memory_read_data,
  output logic        attribute_memory_read_enable,
  output logic [11:0] attribute_memory_read_addr,
  input  logic [7:0]  attribute_memory_read_data,
  output logic        color_memory_read_enable,
  output logic [3:0]  color_memory_read_addr,
  input  logic [7:0]  color_memory_read_data
);

  cpu_req_t  req;
  logic      cpu_rise, commit, ptr_load;
  logic [15:0] ptr_q, ptr_d;
  logic [7:0]  buf_q, buf_d, sel_data, rdata;
  logic        valid_q, valid_d, busy;
  pf_state_e   state_q, state_d;
  region_e     region;

  cpu_clk_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (reset_n),
    .cpu_clk_i(cpu_clk),
    .rise_o   (cpu_rise)
  );

  assign req    = '{rw: rw, addr: addr, wdata: data_in};
  assign commit = cpu_rise & ~cs;

  always_comb begin
    ptr_d    = ptr_q;
    ptr_load = 1'b0;
    if (commit) begin
      if (!req.rw && req.addr == REG_PTR_LO) begin
        ptr_d[7:0] = req.wdata;
        ptr_load   = 1'b1;
      end else if (!req.rw && req.addr == REG_PTR_HI) begin
        ptr_d[15:8] = req.wdata;
        ptr_load    = 1'b1;
      end else if (req.rw && req.addr == REG_DATA) begin
        ptr_d    = ptr_q + 16'd1;
        ptr_load = 1'b1;
      end
    end
  end

  // Region follows the live pointer; a pointer change always restarts the FSM,
  // so ISSUE and CAPTURE never see a region other than the one being fetched.
  assign region = decode_region(ptr_q, COLOR_BASE);

  always_comb begin
    sel_data = 8'h00;
    case (region)
      RGN_TILE:  sel_data = tile_memory_read_data;
      RGN_ATTR:  sel_data = attribute_memory_read_data;
      RGN_COLOR: sel_data = color_memory_read_data;
      default:   sel_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    if (ptr_load) begin
      state_d = PF_ISSUE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        PF_IDLE:    state_d = PF_IDLE;
        PF_ISSUE:   state_d = PF_CAPTURE;
        PF_CAPTURE: begin
          buf_d   = sel_data;
          valid_d = 1'b1;
          state_d = PF_IDLE;
        end
        default:    state_d = PF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= 16'h0000;
      buf_q   <= 8'h00;
      valid_q <= 1'b0;
      state_q <= PF_IDLE;
    end else begin
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign busy = (state_q != PF_IDLE);

  assign tile_memory_read_enable      = (state_q == PF_ISSUE) && (region == RGN_TILE);
  assign attribute_memory_read_enable = (state_q == PF_ISSUE) && (region == RGN_ATTR);
  assign color_memory_read_enable     = (state_q == PF_ISSUE) && (region == RGN_COLOR);

  assign tile_memory_read_addr      = (region == RGN_TILE)  ? 11'(ptr_q - TILE_BASE) : 11'h000;
  assign attribute_memory_read_addr = (region == RGN_ATTR)  ? 12'(ptr_q - ATTR_BASE) : 12'h000;
  assign color_memory_read_addr     = (region == RGN_COLOR) ? ptr_q[3:0]             : 4'h0;

  always_comb begin
    rdata = 8'h00;
    case (addr)
      REG_PTR_LO: rdata = ptr_q[7:0];
      REG_PTR_HI: rdata = ptr_q[15:8];
      REG_DATA:   rdata = buf_q;
      REG_STATUS: rdata = {6'b0, busy, valid_q};
      default:    rdata = 8'h00;
    endcase
  end

  assign data_oe  = ~cs & rw;
  assign data_out = data_oe ? rdata : 8'h00;

endmodule

// File: tb/tb_bus_read_interface.sv
// Directed bench for bus_read_interface: vector table of CPU bus cycles plus
// cycle-exact sequences for mid-prefetch pointer changes and reset.
module tb_bus_read_interface;

  logic        clk = 1'b0, reset_n = 1'b0, cpu_clk = 1'b0;
  logic        cs = 1'b1, rw = 1'b1;
  logic [2:0]  addr = 3'd0;
  logic [7:0]  data_in = 8'h00, data_out;
  logic        data_oe;
  logic        tile_en, attr_en, color_en;
  logic [10:0] tile_addr;
  logic [11:0] attr_addr;
  logic [3:0]  color_addr;
  logic [7:0]  tile_rd = 8'h00, attr_rd = 8'h00, color_rd = 8'h00;

  logic [7:0] tile_mem  [2048];
  logic [7:0] attr_mem  [4096];
  logic [7:0] color_mem [16];

  int total = 0, bad = 0;
  int en_cnt = 0, multi_cnt = 0;

  bus_read_interface dut (
    .clk(clk), .reset_n(reset_n), .cpu_clk(cpu_clk), .cs(cs), .rw(rw),
    .addr(addr), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .tile_memory_read_enable(tile_en), .tile_memory_read_addr(tile_addr),
    .tile_memory_read_data(tile_rd),
    .attribute_memory_read_enable(attr_en), .attribute_memory_read_addr(attr_addr),
    .attribute_memory_read_data(attr_rd),
    .color_memory_read_enable(color_en), .color_memory_read_addr(color_addr),
    .color_memory_read_data(color_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tile_en)  tile_rd  <= tile_mem[tile_addr];
    if (attr_en)  attr_rd  <= attr_mem[attr_addr];
    if (color_en) color_rd <= color_mem[color_addr];
    if (tile_en | attr_en | color_en) en_cnt <= en_cnt + 1;
    if (int'(tile_en) + int'(attr_en) + int'(color_en) > 1) multi_cnt <= multi_cnt + 1;
  end

  typedef struct {
    logic       rw;
    logic [2:0] a;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[40];
  int   nv = 0;

  task automatic add(input logic r, input logic [2:0] a, input logic [7:0] wd,
                     input logic c, input logic [7:0] e);
    tv[nv] = '{rw: r, a: a, wd: wd, chk: c, exp: e};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full CPU bus cycle; read data is sampled before the committing edge.
  task automatic bus_op(input logic r, input logic [2:0] a, input logic [7:0] wd,
                        output logic [7:0] rd);
    @(posedge clk); #1;
    cs = 1'b0; rw = r; addr = a; data_in = wd;
    #2 rd = data_out;
    @(posedge clk); #1 cpu_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1 cpu_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1 cs = 1'b1; rw = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    int snap;

    for (int i = 0; i < 2048; i++) tile_mem[i] = 8'(i);
    for (int i = 0; i < 4096; i++) attr_mem[i] = ~8'(i);
    for (int i = 0; i < 16; i++)   color_mem[i] = 8'hD0 | 8'(i);
    tile_mem[12'h100] = 8'haa;  tile_mem[12'h7FF] = 8'h5a;
    tile_mem[12'h110] = 8'h11;  tile_mem[12'h210] = 8'h21;
    attr_mem[12'h100] = 8'h0e;  attr_mem[12'h000] = 8'h3c;
    attr_mem[12'hFFF] = 8'h77;  color_mem[2]      = 8'hbe;

    add(0,4,8'h00,0,8'h00); add(0,5,8'h01,0,8'h00);
    add(1,6,8'h00,1,8'haa); add(1,4,8'h00,1,8'h01); add(1,5,8'h00,1,8'h01);
    add(1,7,8'h00,1,8'h01);
    add(0,4,8'h00,0,8'h00); add(0,5,8'h09,0,8'h00); add(1,6,8'h00,1,8'h0e);
    add(0,4,8'h02,0,8'h00); add(0,5,8'h18,0,8'h00); add(1,6,8'h00,1,8'hbe);
    add(0,4,8'hFF,0,8'h00); add(0,5,8'h07,0,8'h00);
    add(1,6,8'h00,1,8'h5a); add(1,6,8'h00,1,8'h3c); add(1,4,8'h00,1,8'h01);
    add(0,6,8'h77,0,8'h00); add(0,7,8'h55,0,8'h00); add(0,0,8'h12,0,8'h00);
    add(1,4,8'h00,1,8'h01); add(1,5,8'h00,1,8'h08);
    add(1,0,8'h00,1,8'h00); add(1,3,8'h00,1,8'h00);
    add(0,4,8'hFF,0,8'h00); add(0,5,8'h17,0,8'h00);
    add(1,6,8'h00,1,8'h77); add(1,6,8'h00,1,8'hD0);
    add(0,4,8'h10,0,8'h00); add(1,6,8'h00,1,8'h00);

    // reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_oe", data_oe, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_en", {tile_en, attr_en, color_en}, 0);
    chk("rst_addrs", {tile_addr, attr_addr, color_addr}, 0);
    cs = 1'b0; rw = 1'b1; addr = 3'd7; #1;
    chk("rst_oe_read", data_oe, 1);
    chk("rst_status", data_out, 8'h00);
    cs = 1'b1;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < nv; i++) begin
      bus_op(tv[i].rw, tv[i].a, tv[i].wd, rd);
      if (tv[i].chk) chk($sformatf("vec%0d", i), rd, tv[i].exp);
    end

    // unmapped pointer: no enable, buffer reads 00, pointer wraps
    bus_op(0, 4, 8'hFF, rd);
    snap = en_cnt;
    bus_op(0, 5, 8'hFF, rd);
    chk("unmapped_no_en", en_cnt - snap, 0);
    bus_op(1, 6, 8'h00, rd);  chk("unmapped_data", rd, 8'h00);
    bus_op(1, 4, 8'h00, rd);  chk("wrap_lo", rd, 8'h00);
    bus_op(1, 5, 8'h00, rd);  chk("wrap_hi", rd, 8'h00);

    // pointer rewritten while the first read is in flight
    bus_op(0, 5, 8'h01, rd);
    @(posedge clk); #1;
    cs = 1'b0; rw = 1'b0; addr = 3'd4; data_in = 8'h10; cpu_clk = 1'b1;
    @(posedge clk); #1 cpu_clk = 1'b0;
    @(posedge clk); #1 cpu_clk = 1'b1;
    @(posedge clk); #1;
    chk("flight_issue1_en", tile_en, 1);
    chk("flight_issue1_addr", tile_addr, 11'h110);
    addr = 3'd5; data_in = 8'h02;
    @(posedge clk);
    @(posedge clk); #1;
    rw = 1'b1; addr = 3'd7; cpu_clk = 1'b0; #1;
    chk("flight_busy_status", data_out, 8'h02);
    chk("flight_issue2_addr", {tile_en, tile_addr}, {1'b1, 11'h210});
    repeat (2) @(posedge clk); #1;
    chk("flight_valid_status", data_out, 8'h01);
    addr = 3'd6; #1;
    chk("flight_data", data_out, 8'h21);
    cs = 1'b1;
    repeat (3) @(posedge clk);

    // reset asserted during CAPTURE
    @(posedge clk); #1;
    cs = 1'b0; rw = 1'b0; addr = 3'd4; data_in = 8'h20; cpu_clk = 1'b1;
    repeat (3) @(posedge clk); #1;
    cpu_clk = 1'b0;
    chk("capt_issue_en", {tile_en, tile_addr}, {1'b1, 11'h220});
    @(posedge clk); #1;
    reset_n = 1'b0; rw = 1'b1; addr = 3'd7; #1;
    chk("mid_rst_en", {tile_en, attr_en, color_en}, 0);
    chk("mid_rst_addrs", {tile_addr, attr_addr, color_addr}, 0);
    chk("mid_rst_status", data_out, 8'h00);
    addr = 3'd5; #1;
    chk("mid_rst_ptr_hi", data_out, 8'h00);
    addr = 3'd6; #1;
    chk("mid_rst_buf", data_out, 8'h00);
    @(posedge clk); #1 reset_n = 1'b1;
    snap = en_cnt;
    addr = 3'd7;
    repeat (6) @(posedge clk); #1;
    chk("post_rst_idle", data_out, 8'h00);
    chk("post_rst_no_en", en_cnt - snap, 0);
    cs = 1'b1;

    chk("single_enable", multi_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_read_interface.md
BUS_READ_INTERFACE -- requirements
Module: bus_read_interface

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of flops used to synchronise cpu_clk into clk.
REQ-002 SHALL have parameter COLOR_BASE, default 16'h1800, start address of the color region.
REQ-003 SHALL have ports: clk in 1, GPU system clock; reset_n in 1, reset, asynchronous active-low.
REQ-004 SHALL have ports: cpu_clk in 1, CPU bus clock; cs in 1, chip select, active-low; rw in 1, 1=read 0=write; addr in 3, register select.
REQ-005 SHALL have ports: data_in in 8, CPU write data; data_out out 8, CPU read data; data_oe out 1, bus drive enable.
REQ-006 SHALL have tile port: tile_memory_read_enable out 1; tile_memory_read_addr out 11; tile_memory_read_data in 8.
REQ-007 SHALL have attribute port: attribute_memory_read_enable out 1; attribute_memory_read_addr out 12; attribute_memory_read_data in 8.
REQ-008 SHALL have color port: color_memory_read_enable out 1; color_memory_read_addr out 4; color_memory_read_data in 8.

Function
REQ-009 Register map: 4=pointer low, 5=pointer high, 6=data port (read), 7=status (read-only); others read 8'h00.
REQ-010 A commit event is a rising edge of synchronised cpu_clk while cs=0.
REQ-011 On commit: write to 4/5 loads that pointer byte from data_in; read of 6 post-increments the 16-bit pointer; other commits do not change the pointer.
REQ-012 Pointer increment wraps 16'hFFFF -> 16'h0000.
REQ-013 Decode: 0x0000-0x07FF tile (addr = ptr[10:0]); 0x0800-0x17FF attribute (addr = ptr-0x0800, 12 bits); COLOR_BASE..+0xF color (addr = ptr[3:0]); all else unmapped.
REQ-014 Prefetch FSM states IDLE, ISSUE, CAPTURE.
REQ-015 Any pointer change moves the FSM to ISSUE from any state and clears prefetch_valid.
REQ-016 In ISSUE, exactly one read_enable of the decoded memory is high for one clk, with its address; the FSM then moves to CAPTURE.
REQ-017 In CAPTURE, the selected read_data is registered into the prefetch buffer, prefetch_valid is set, and the FSM returns to IDLE.
REQ-018 For an unmapped pointer, no read_enable is asserted; the buffer loads 8'h00 and valid is set.
REQ-019 prefetch_valid SHALL be set no later than SYNC_STAGES+3 clk after the cpu_clk rising edge that changed the pointer.
REQ-020 If the pointer changes during ISSUE/CAPTURE, the in-flight result is discarded, the read restarts in ISSUE, and a stale value is never marked valid.
REQ-021 data_oe = ~cs & rw, combinational; data_out is 8'h00 when data_oe=0.
REQ-022 data_out: reg 4/5 = pointer bytes; reg 6 = prefetch buffer; reg 7 = {6'b0, fsm_busy, prefetch_valid}.
REQ-023 Writes to 6/7 are ignored by this block; the write path belongs to bus_interface.
REQ-024 All read_enable outputs are low outside ISSUE.

Reset
REQ-025 reset_n low SHALL asynchronously clear pointer, buffer, prefetch_valid, synchroniser flops and all read_enables, and set the FSM to IDLE.
REQ-026 Reset mid-prefetch SHALL abort the read; after release the FSM stays in IDLE until the next pointer change.
REQ-027 Read addresses SHALL reset to 0; data_out follows REQ-021 during reset.

Structure
REQ-028 Shared package gpu_bus_pkg SHALL hold register indices 4..7, region bases/limits, and the FSM state encoding, shared with bus_interface.
REQ-029 One sub-module, cpu_clk_sync (synchroniser plus rising-edge detect), SHALL be used and is reusable by bus_interface.

Verification
REQ-030 Memories preloaded tile[0x100]=aa; write 4<-00, 5<-01; wait valid; read 6 -> aa, pointer becomes 0x0101.
REQ-031 Pointer 0x0900, attribute[0x100]=0e: read 6 -> 0e; pointer 0x1802, color[2]=be: read 6 -> be.
REQ-032 Pointer 0x07FF, read 6 twice: first returns tile[0x7FF], second returns attribute[0x000].
REQ-033 Pointer 0xFFFF: read 6 -> 00 with no read_enable asserted; pointer wraps to 0x0000.
REQ-034 Write 5 one clk into ISSUE: only the new address is captured; status reads 02 while busy, then 01.
REQ-035 Assert reset_n low during CAPTURE: all outputs and registers return to reset values, and status reads 00.
